onchip_mem_copy_master: RTL

- Avalon-MM initiator that drives the single-port on-chip RAM slave (32-bit data, 14-bit word address, byte enables, clken, unregistered read data).
- Copies a block of LEN 32-bit words from SRC to DST word addresses in the same RAM: read, wait for read latency, capture, write.
- Sits beside the Nios II data master behind the interconnect, so bulk memory moves do not need CPU loops.

---
 rtl/onchip_mem_copy_master_if.sv | 28 ++
 rtl/onchip_mem_copy_master.sv | 135 +++++++++++++
 2 files changed

// File: rtl/onchip_mem_copy_master_if.sv
// Avalon-MM bus bundle for the single-port on-chip RAM.
// The copy master drives the master modport and the RAM sits on the slave modport.
interface onchip_mem_copy_master_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic [DATA_W-1:0]   readdata;

  // A read is accepted on any clock edge where chipselect is high and write is low.
  // Its readdata is valid READ_LATENCY edges later.
  // A write is committed on the clock edge where chipselect and write are both high.
  // The bus has no wait states, so there is no ready/waitrequest signal.
  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/onchip_mem_copy_master.sv
// Block copy engine for the on-chip RAM: read a word, wait for the read latency, write it out.
// Optional running checksum output is enabled by defining ONCHIP_MEM_COPY_CHECKSUM_EN.
module onchip_mem_copy_master #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     len_words,
  output logic                busy,
  output logic                done,
  output logic [2:0]          fsm_state,
  onchip_mem_copy_master_if.master avm
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAT  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W:0]   remaining;
  logic [LAT_W-1:0]  lat_cnt;

  assign fsm_state = state;
  assign avm.clken = ~reset;

  // Bus outputs are set on the edge that enters a state, so each one is valid for the whole state.
  // writedata also serves as the register that holds the captured word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      avm.chipselect <= 1'b0;
      avm.write      <= 1'b0;
      avm.address    <= '0;
      avm.writedata  <= '0;
      avm.byteenable <= '0;
      src_ptr        <= '0;
      dst_ptr        <= '0;
      remaining      <= '0;
      lat_cnt        <= '0;
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
            checksum <= '0;
`endif
            if (len_words != '0) begin
              src_ptr        <= src_addr;
              dst_ptr        <= dst_addr;
              remaining      <= len_words;
              state          <= RD;
              busy           <= 1'b1;
              avm.chipselect <= 1'b1;
              avm.write      <= 1'b0;
              avm.address    <= src_addr;
              avm.byteenable <= '1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RD: begin
          state          <= LAT;
          avm.chipselect <= 1'b0;
          avm.byteenable <= '0;
          lat_cnt        <= LAT_W'(READ_LATENCY - 1);
        end
        LAT: begin
          if (lat_cnt == '0) begin
            avm.writedata  <= avm.readdata;
            state          <= WR;
            avm.chipselect <= 1'b1;
            avm.write      <= 1'b1;
            avm.address    <= dst_ptr;
            avm.byteenable <= '1;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        WR: begin
          src_ptr   <= src_ptr + ADDR_W'(1);
          dst_ptr   <= dst_ptr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
          avm.write <= 1'b0;
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
          checksum  <= checksum + avm.writedata;
`endif
          if (remaining == (ADDR_W+1)'(1)) begin
            state          <= FIN;
            avm.chipselect <= 1'b0;
            avm.byteenable <= '0;
            busy           <= 1'b0;
            done           <= 1'b1;
          end else begin
            state          <= RD;
            avm.chipselect <= 1'b1;
            avm.byteenable <= '1;
            avm.address    <= src_ptr + ADDR_W'(1);
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
